// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and helpers for the MIPS load/store path.
//   mem_size_e   - access width after decoding the raw 2-bit size field
//   lsu_state_e  - load/store unit controller states
//   *_SHIFT      - big-endian lane positions (byte lane k sits at bits 31-8k:24-8k)
//   decode_size  - maps the raw size field onto mem_size_e (reserved code acts as word)
//   byte_shift / half_shift - lane shift amount for a given low address
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } lsu_state_e;

    // Big-endian: the lowest address holds the most significant lane.
    localparam logic [4:0] LANE0_SHIFT   = 5'd24;
    localparam logic [4:0] LANE1_SHIFT   = 5'd16;
    localparam logic [4:0] LANE2_SHIFT   = 5'd8;
    localparam logic [4:0] LANE3_SHIFT   = 5'd0;
    localparam logic [4:0] HALF_HI_SHIFT = 5'd16;
    localparam logic [4:0] HALF_LO_SHIFT = 5'd0;

    function automatic mem_size_e decode_size(input logic [1:0] raw);
        mem_size_e sz;
        case (raw)
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic [4:0] byte_shift(input logic [1:0] lo);
        logic [4:0] sh;
        case (lo)
            2'b00:   sh = LANE0_SHIFT;
            2'b01:   sh = LANE1_SHIFT;
            2'b10:   sh = LANE2_SHIFT;
            default: sh = LANE3_SHIFT;
        endcase
        return sh;
    endfunction

    function automatic logic [4:0] half_shift(input logic hi_sel);
        logic [4:0] sh;
        if (hi_sel) begin
            sh = HALF_LO_SHIFT;
        end else begin
            sh = HALF_HI_SHIFT;
        end
        return sh;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the load/store unit.
// Ports:
//   old_word    in  32  word currently held in memory
//   new_data    in  32  right-justified store data
//   size        in  2   raw access size (00 byte, 01 half, 1x word)
//   is_signed   in  1   sign-extend loads when 1
//   addr_lo     in  2   byte offset within the word
//   merged_word out 32  old_word with the addressed lane(s) replaced by new_data
//   load_word   out 32  addressed lane(s) of old_word, right-justified and extended
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged_word,
    output logic [31:0] load_word
);

    function automatic logic [31:0] merge_store(input logic [31:0] old_w,
                                                input logic [31:0] new_d,
                                                input mem_size_e   sz,
                                                input logic [1:0]  lo);
        logic [4:0]  sh;
        logic [31:0] mask;
        logic [31:0] res;
        sh   = 5'd0;
        mask = 32'h0000_0000;
        case (sz)
            SZ_BYTE: begin
                sh   = byte_shift(lo);
                mask = 32'h0000_00FF << sh;
                res  = (old_w & ~mask) | ({24'h00_0000, new_d[7:0]} << sh);
            end
            SZ_HALF: begin
                sh   = half_shift(lo[1]);
                mask = 32'h0000_FFFF << sh;
                res  = (old_w & ~mask) | ({16'h0000, new_d[15:0]} << sh);
            end
            default: begin
                res = new_d;
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input mem_size_e   sz,
                                                 input logic        sgn,
                                                 input logic [1:0]  lo);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = 32'h0000_0000;
        case (sz)
            SZ_BYTE: begin
                shifted = word >> byte_shift(lo);
                if (sgn) begin
                    res = {{24{shifted[7]}}, shifted[7:0]};
                end else begin
                    res = {24'h00_0000, shifted[7:0]};
                end
            end
            SZ_HALF: begin
                shifted = word >> half_shift(lo[1]);
                if (sgn) begin
                    res = {{16{shifted[15]}}, shifted[15:0]};
                end else begin
                    res = {16'h0000, shifted[15:0]};
                end
            end
            default: begin
                res = word;
            end
        endcase
        return res;
    endfunction

    // Both results are always available; the controller picks which one to use.
    always_comb begin
        merged_word = merge_store(old_word, new_data, decode_size(size), addr_lo);
        load_word   = extract_load(old_word, decode_size(size), is_signed, addr_lo);
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage bridge from MIPS byte/half/word loads and stores
// to a word-wide data memory without byte enables. Sub-word stores become a
// read (stall cycle) followed by a write of the merged word.
// Ports:
//   clk, reset_n                 clock and synchronous active-low reset
//   req_valid/write/size/signed  request qualifiers from EX/MEM
//   req_addr, req_wdata          byte address and right-justified store data
//   stall                        holds the pipeline during the RMW read cycle
//   load_data, load_valid        registered, extended load result and its pulse
//   misalign_exc, bad_addr       registered misalignment pulse and offending address
//   dm_addr, dm_wdata            word index and write data to data memory
//   dm_write_en, dm_read         data memory strobes
//   dm_rdata                     combinational memory read data
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int DM_IDX_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              misalign_exc,
    output logic [ADDR_W-1:0] bad_addr,
    output logic [31:0]       dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_write_en,
    output logic              dm_read,
    input  logic [DATA_W-1:0] dm_rdata
);

    lsu_state_e          state_q, state_d;
    logic [DATA_W-1:0]   merge_q, merge_d;
    logic [DM_IDX_W-1:0] rmw_idx_q, rmw_idx_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic                load_valid_q, load_valid_d;
    logic                misalign_exc_q, misalign_exc_d;
    logic [ADDR_W-1:0]   bad_addr_q, bad_addr_d;

    mem_size_e           size_s;
    logic                misaligned_s;
    logic [DATA_W-1:0]   merged_s;
    logic [DATA_W-1:0]   extracted_s;
    logic                dm_read_s;
    logic                dm_write_s;
    logic                stall_s;
    logic [DATA_W-1:0]   dm_wdata_s;
    logic [DM_IDX_W-1:0] dm_idx_s;

    mem_lane_align u_align (
        .old_word    (dm_rdata),
        .new_data    (req_wdata),
        .size        (req_size),
        .is_signed   (req_signed),
        .addr_lo     (req_addr[1:0]),
        .merged_word (merged_s),
        .load_word   (extracted_s)
    );

    // Alignment check: halves need an even address, words a multiple of four.
    always_comb begin
        size_s = decode_size(req_size);
        case (size_s)
            SZ_HALF: misaligned_s = req_addr[0];
            SZ_WORD: misaligned_s = |req_addr[1:0];
            default: misaligned_s = 1'b0;
        endcase
    end

    // Controller next state, memory strobes and registered-output next values.
    always_comb begin
        state_d        = state_q;
        merge_d        = merge_q;
        rmw_idx_d      = rmw_idx_q;
        load_data_d    = load_data_q;
        load_valid_d   = 1'b0;
        misalign_exc_d = 1'b0;
        bad_addr_d     = bad_addr_q;
        dm_read_s      = 1'b0;
        dm_write_s     = 1'b0;
        stall_s        = 1'b0;
        dm_wdata_s     = req_wdata;
        dm_idx_s       = req_addr[DM_IDX_W+1:2];
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned_s) begin
                        misalign_exc_d = 1'b1;
                        bad_addr_d     = req_addr;
                    end else if (!req_write) begin
                        dm_read_s    = 1'b1;
                        load_data_d  = extracted_s;
                        load_valid_d = 1'b1;
                    end else if (size_s == SZ_WORD) begin
                        dm_write_s = 1'b1;
                    end else begin
                        // Sub-word store: read now, write the merged word next cycle.
                        dm_read_s = 1'b1;
                        stall_s   = 1'b1;
                        merge_d   = merged_s;
                        rmw_idx_d = req_addr[DM_IDX_W+1:2];
                        state_d   = RMW_WRITE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RMW_WRITE: begin
                // The held store completes here; req_valid is not examined.
                dm_write_s = 1'b1;
                dm_wdata_s = merge_q;
                dm_idx_s   = rmw_idx_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            merge_q        <= {DATA_W{1'b0}};
            rmw_idx_q      <= {DM_IDX_W{1'b0}};
            load_data_q    <= {DATA_W{1'b0}};
            load_valid_q   <= 1'b0;
            misalign_exc_q <= 1'b0;
            bad_addr_q     <= {ADDR_W{1'b0}};
        end else begin
            state_q        <= state_d;
            merge_q        <= merge_d;
            rmw_idx_q      <= rmw_idx_d;
            load_data_q    <= load_data_d;
            load_valid_q   <= load_valid_d;
            misalign_exc_q <= misalign_exc_d;
            bad_addr_q     <= bad_addr_d;
        end
    end

    // Strobes are gated by reset so a pending RMW write is dropped immediately.
    assign dm_read      = reset_n & dm_read_s;
    assign dm_write_en  = reset_n & dm_write_s;
    assign stall        = reset_n & stall_s;
    assign dm_wdata     = dm_wdata_s;
    assign dm_addr      = {{(32-DM_IDX_W){1'b0}}, dm_idx_s};
    assign load_data    = load_data_q;
    assign load_valid   = load_valid_q;
    assign misalign_exc = misalign_exc_q;
    assign bad_addr     = bad_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit. A byte-addressed
// big-endian reference memory predicts each load result or misalignment
// exception; a monitor pops predictions whenever the unit pulses an output.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign_exc;
    logic [31:0] bad_addr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_write_en;
    logic        dm_read;
    logic [31:0] dm_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic mem_ready = 1'b0;

    typedef struct {
        logic        exc;
        logic [31:0] data;
        logic [31:0] addr;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_mon;

    logic [31:0] env_mem [0:255];
    logic [7:0]  ref_b   [0:1023];

    load_store_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .misalign_exc (misalign_exc),
        .bad_addr     (bad_addr),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_write_en  (dm_write_en),
        .dm_read      (dm_read),
        .dm_rdata     (dm_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] t;
        t = 32'(i + 1);
        return (t * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Environment data memory: combinational read, write on clock edge.
    assign dm_rdata = env_mem[dm_addr[7:0]];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
        end else if (dm_write_en) begin
            env_mem[dm_addr[7:0]] <= dm_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte memory, big-endian, right-justified store data.
    task automatic model_apply(input logic w, input logic [1:0] sz, input logic sg,
                               input logic [31:0] a, input logic [31:0] wd);
        int n;
        int base;
        logic mis;
        logic [31:0] val;
        exp_t e;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = int'(a[9:0]);
        mis  = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        if (mis) begin
            e.exc = 1'b1; e.data = 32'h0; e.addr = a;
            exp_q.push_back(e);
        end else if (w) begin
            for (int k = 0; k < n; k++) ref_b[base + k] = 8'(wd >> (8 * (n - 1 - k)));
        end else begin
            val = 32'h0;
            for (int k = 0; k < n; k++) val = (val << 8) | {24'h0, ref_b[base + k]};
            if (sg && n < 4 && val[8 * n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
            e.exc = 1'b0; e.data = val; e.addr = a;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input bit use_model);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_signed = sg; req_addr = a; req_wdata = wd;
        if (use_model) model_apply(w, sz, sg, a, wd);
    endtask

    // Waits until the request is taken at an edge with stall low (bounded).
    task automatic wait_accept();
        logic st;
        int n;
        bit done;
        n = 0; done = 1'b0;
        while (!done) begin
            #1 st = stall;
            @(posedge clk);
            if (!st) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 3) begin
                    n_checks++; n_fail++;
                    $display("FAIL stall_timeout: got stall held %0d cycles expected <=1", n);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        drive(w, sz, sg, a, wd, 1'b1);
        wait_accept();
    endtask

    task automatic load_expect(input logic [1:0] sz, input logic sg,
                               input logic [31:0] a, input logic [31:0] exp, input string name);
        issue(1'b0, sz, sg, a, 32'h0);
        #1;
        check({name, "_valid"}, {31'h0, load_valid}, 32'h1);
        check(name, load_data, exp);
    endtask

    task automatic go_idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Monitor: every output pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (reset_n && (load_valid || misalign_exc)) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_response: got valid=%b exc=%b expected none",
                         load_valid, misalign_exc);
            end else begin
                e_mon = exp_q.pop_front();
                check("resp_exc", {31'h0, misalign_exc}, {31'h0, e_mon.exc});
                check("resp_valid", {31'h0, load_valid}, {31'h0, ~e_mon.exc});
                if (e_mon.exc) check("resp_bad_addr", bad_addr, e_mon.addr);
                else           check("resp_load_data", load_data, e_mon.data);
            end
        end
    end

    initial begin
        logic [31:0] w0;
        int t0;
        logic [31:0] ra;
        for (int i = 0; i < 256; i++) begin
            w0 = init_word(i);
            ref_b[4*i] = w0[31:24]; ref_b[4*i+1] = w0[23:16];
            ref_b[4*i+2] = w0[15:8]; ref_b[4*i+3] = w0[7:0];
        end

        // Reset with a sub-word store pending on the inputs: strobes stay low.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_dm_read", {31'h0, dm_read}, 32'h0);
        check("rst_dm_we", {31'h0, dm_write_en}, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_load_valid", {31'h0, load_valid}, 32'h0);
        check("rst_misalign", {31'h0, misalign_exc}, 32'h0);
        check("rst_bad_addr", bad_addr, 32'h0);
        mem_ready = 1'b1; reset_n = 1'b1; req_valid = 1'b0;

        // SW 0x10: single-cycle write.
        drive(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1);
        #1;
        check("sw_dm_addr", dm_addr, 32'h4);
        check("sw_dm_we", {31'h0, dm_write_en}, 32'h1);
        check("sw_stall", {31'h0, stall}, 32'h0);
        check("sw_dm_wdata", dm_wdata, 32'hDEAD_BEEF);
        @(posedge clk);
        load_expect(2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, "lw_after_sw");

        // SB 0x11: read cycle with stall, then merged write.
        drive(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA, 1'b1);
        #1;
        check("sb_c0_stall", {31'h0, stall}, 32'h1);
        check("sb_c0_read", {31'h0, dm_read}, 32'h1);
        check("sb_c0_we", {31'h0, dm_write_en}, 32'h0);
        @(posedge clk);
        #1;
        check("sb_c1_we", {31'h0, dm_write_en}, 32'h1);
        check("sb_c1_wdata", dm_wdata, 32'hDEAA_BEEF);
        check("sb_c1_stall", {31'h0, stall}, 32'h0);
        check("sb_c1_addr", dm_addr, 32'h4);
        @(posedge clk);
        load_expect(2'b10, 1'b0, 32'h10, 32'hDEAA_BEEF, "lw_after_sb");
        load_expect(2'b00, 1'b1, 32'h11, 32'hFFFF_FFAA, "lb");
        load_expect(2'b00, 1'b0, 32'h11, 32'h0000_00AA, "lbu");
        load_expect(2'b01, 1'b1, 32'h12, 32'hFFFF_BEEF, "lh");
        load_expect(2'b01, 1'b0, 32'h12, 32'h0000_BEEF, "lhu");
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234);
        load_expect(2'b10, 1'b0, 32'h10, 32'hDEAA_1234, "lw_after_sh");

        // Misaligned word load and half store.
        drive(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b1);
        #1;
        check("mis_lw_read", {31'h0, dm_read}, 32'h0);
        check("mis_lw_stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1;
        check("mis_lw_exc", {31'h0, misalign_exc}, 32'h1);
        check("mis_lw_bad", bad_addr, 32'h13);
        check("mis_lw_valid", {31'h0, load_valid}, 32'h0);
        drive(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_5555, 1'b1);
        #1;
        check("mis_sh_we", {31'h0, dm_write_en}, 32'h0);
        check("mis_sh_read", {31'h0, dm_read}, 32'h0);
        @(posedge clk);
        #1;
        check("mis_sh_exc", {31'h0, misalign_exc}, 32'h1);
        check("mis_sh_bad", bad_addr, 32'h11);
        go_idle();
        @(posedge clk);
        #1;
        check("exc_one_pulse", {31'h0, misalign_exc}, 32'h0);
        check("load_data_hold", load_data, 32'hDEAA_1234);

        // Reset during the RMW write cycle drops the write.
        issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h1122_3344);
        drive(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_0055, 1'b0);
        #1;
        check("rmwrst_c0_stall", {31'h0, stall}, 32'h1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rmwrst_we", {31'h0, dm_write_en}, 32'h0);
        check("rmwrst_stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1;
        check("rmwrst_mem", env_mem[12], 32'h1122_3344);
        check("rmwrst_load_data", load_data, 32'h0);
        check("rmwrst_bad_addr", bad_addr, 32'h0);
        check("rmwrst_exc", {31'h0, misalign_exc}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1; req_valid = 1'b0;
        load_expect(2'b10, 1'b0, 32'h30, 32'h1122_3344, "lw_after_rmwrst");

        // SH then LW back-to-back: load sees the merged word, valid 3 cycles later.
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D);
        drive(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000_1234, 1'b1);
        t0 = cyc;
        wait_accept();
        load_expect(2'b10, 1'b0, 32'h20, 32'h1234_F00D, "b2b_lw");
        check("b2b_latency", 32'(cyc - t0), 32'd3);

        // Randomized traffic over a small window with random upper address bits.
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ra, $urandom);
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        for (int i = 0; i < 256; i++) begin
            check("final_mem", env_mem[i],
                  {ref_b[4*i], ref_b[4*i+1], ref_b[4*i+2], ref_b[4*i+3]});
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
